modport_ctrl: RTL and testbench
===============================

Name: modport_ctrl

Overview:
- Two-road traffic-light controller (FSMD) for a crossing of street A and street B.
- Car sensors ta/tb request service; Moore outputs la/lb drive each road's light.
- A small datapath counter enforces minimum green and fixed yellow durations.
- Sits directly behind the bench interface: the BFM drives ta/tb, the monitor samples la/lb.

Parameters:
- MIN_GREEN, 1, minimum cycles a road stays green before it may yield (legal range >=1).
- YELLOW_CYCLES, 5, exact number of cycles each yellow phase lasts (legal range >=1).
- CNT_W, 8, counter width; must satisfy 2**CNT_W > max(MIN_GREEN, YELLOW_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ta   input  1  street-A traffic sensor, 1 = car present/approaching on A.
- tb   input  1  street-B traffic sensor, 1 = car present/approaching on B.
- la   output 2  street-A light: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED; 2'b11 is never driven.
- lb   output 2  street-B light, same encoding.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst low asynchronously forces state S0 and cnt=0; outputs take S0 values immediately.
  - Release of rst is synchronous to the next rising edge.
  - Reset asserted mid-phase (including mid-yellow) aborts the phase and returns to S0.
- States (2-bit register) with Moore outputs decoded combinationally from state only:
  - S0: la=GREEN, lb=RED.
  - S1: la=YELLOW, lb=RED.
  - S2: la=RED, lb=GREEN.
  - S3: la=RED, lb=YELLOW.
- Datapath counter cnt:
  - Clears to 0 on every state transition.
  - Otherwise increments by 1 per cycle and saturates at all-ones (no wrap).
- Transitions, evaluated at each rising edge using the ta/tb values sampled at that edge:
  - S0 -> S1 when ta==0 and cnt >= MIN_GREEN-1; otherwise stay in S0. tb is ignored in S0.
  - S1 -> S2 when cnt == YELLOW_CYCLES-1, unconditionally on sensors. Yellow therefore lasts exactly YELLOW_CYCLES cycles.
  - S2 -> S3 when tb==0 and cnt >= MIN_GREEN-1; otherwise stay. ta is ignored in S2.
  - S3 -> S0 when cnt == YELLOW_CYCLES-1, unconditionally.
  - Illegal state encodings, if ever reached, go to S0 on the next edge.
- Latency: la/lb change in the same cycle the state register updates, i.e. one edge after the qualifying sensor sample.
- Safety invariants:
  - Never both roads non-RED simultaneously.
  - Never a direct GREEN -> RED transition; YELLOW is always interposed.
- Simultaneous events: ta and tb both 0 in S0 gives the normal S0 -> S1; the next green (B) is still served in full, with its MIN_GREEN honoured.
- Both sensors held 1: the controller stays in the current green indefinitely. There is no fairness timeout.

Test Plan:
- Reset: hold rst=0 for 3 cycles with ta=tb=0 -> la=00, lb=10 throughout; state stays S0 while reset is asserted.
- Hold A: release rst, ta=1, tb=1 for 20 cycles -> la=00 and lb=10 every cycle, no transition.
- Full cycle: ta=0, tb=1 -> next edge la=01, lb=10 for exactly 5 cycles; then la=10, lb=00 held while tb=1. Drop tb=0 -> la=10, lb=01 for 5 cycles, then back to la=00, lb=10.
- Yellow ignores sensors: toggle ta/tb every cycle during S1 -> yellow still exactly 5 cycles and S2 is always reached.
- MIN_GREEN=4 build: enter S2 with tb=0 already low -> lb=00 for exactly 4 cycles before lb=01.
- Reset mid-yellow: assert rst=0 during the 3rd cycle of S3 -> la=00, lb=10 immediately (asynchronous). After release, the next yellow lasts a full 5 cycles.
- Invariant check on all of the above: every cycle, (la!=2'b10 && lb!=2'b10) never occurs and 2'b11 never appears.

Source files
------------

// File: rtl/modport_ctrl.sv
// Two-road traffic-light controller: Moore FSM over a saturating phase counter.
// Street A is served first after reset; each green may yield only once its own sensor drops.
module modport_ctrl #(
  parameter int unsigned MIN_GREEN     = 1,
  parameter int unsigned YELLOW_CYCLES = 5,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb
);

  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_e;

  localparam logic [1:0] Green  = 2'b00;
  localparam logic [1:0] Yellow = 2'b01;
  localparam logic [1:0] Red    = 2'b10;

  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0:      if (!ta && cnt_q >= GreenLast) state_d = S1;
      S1:      if (cnt_q == YellowLast) state_d = S2;
      S2:      if (!tb && cnt_q >= GreenLast) state_d = S3;
      S3:      if (cnt_q == YellowLast) state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Counter measures time spent in the current phase; it never wraps so a
  // long-held green stays eligible to yield.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    la = Red;
    lb = Red;
    unique case (state_q)
      S0:      la = Green;
      S1:      la = Yellow;
      S2:      lb = Green;
      S3:      lb = Yellow;
      default: begin
        la = Red;
        lb = Red;
      end
    endcase
  end

endmodule

// File: tb/tb_modport_ctrl.sv
// Bench for modport_ctrl: a default build and a MIN_GREEN=4 / 3-bit-counter build
// run in lockstep against a phase/elapsed-time reference model.
module tb_modport_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ta  = 1'b0;
  logic       tb  = 1'b0;
  logic [1:0] la0, lb0, la1, lb1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  modport_ctrl #(.MIN_GREEN(1), .YELLOW_CYCLES(5), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la0), .lb(lb0)
  );

  modport_ctrl #(.MIN_GREEN(4), .YELLOW_CYCLES(5), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb), .la(la1), .lb(lb1)
  );

  // Phase 0 = A green, 1 = A yellow, 2 = B green, 3 = B yellow.
  // el = number of whole cycles already spent in the phase.
  localparam int Yc = 5;
  int         mg[2] = '{1, 4};
  int         phase[2];
  int         el[2];
  logic [1:0] la_tab[4] = '{2'b00, 2'b01, 2'b10, 2'b10};
  logic [1:0] lb_tab[4] = '{2'b10, 2'b10, 2'b00, 2'b01};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0;
      el[k]    = 0;
    end
  endtask

  task automatic model_edge(input logic a, input logic b);
    for (int k = 0; k < 2; k++) begin
      int  served;
      bit  adv;
      served = el[k] + 1;
      if (phase[k] == 0)      adv = !a && served >= mg[k];
      else if (phase[k] == 2) adv = !b && served >= mg[k];
      else                    adv = served == Yc;
      if (adv) begin
        phase[k] = (phase[k] + 1) % 4;
        el[k]    = 0;
      end else begin
        el[k] = served;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input int k, input logic [1:0] la, input logic [1:0] lb);
    chk({nm, " la"}, {6'd0, la}, {6'd0, la_tab[phase[k]]});
    chk({nm, " lb"}, {6'd0, lb}, {6'd0, lb_tab[phase[k]]});
    chk({nm, " both_non_red"}, {7'd0, (la != 2'b10) && (lb != 2'b10)}, 8'd0);
    chk({nm, " code_11"}, {7'd0, (la == 2'b11) || (lb == 2'b11)}, 8'd0);
  endtask

  task automatic check_all();
    check_dut("dut0", 0, la0, lb0);
    check_dut("dut1", 1, la1, lb1);
  endtask

  task automatic step(input logic a, input logic b);
    ta = a;
    tb = b;
    @(posedge clk);
    if (rst) model_edge(a, b);
    #1;
    check_all();
  endtask

  initial begin
    int  yel;
    bit  found;
    model_reset();

    // Reset held with sensors low.
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Both sensors high: A keeps green.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // A yields, B held green long enough to saturate the 3-bit counter.
    yel = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1);
      if (la0 == 2'b01) yel++;
    end
    chk("dut0 yellow_len_a", 8'(yel), 8'd5);

    // B yields back to A; A held.
    yel = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (lb0 == 2'b01) yel++;
    end
    chk("dut0 yellow_len_b", 8'(yel), 8'd5);

    // Sensors toggle throughout A's yellow; B green still reached.
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i[0], ~i[0]);
    chk("dut0 s2_after_toggle", {6'd0, lb0}, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

    // MIN_GREEN=4 build enters B green with tb already low.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0);
      if (phase[1] == 2) found = 1'b1;
    end
    chk("dut1 reach_b_green", {7'd0, found}, 8'd1);
    yel = 0;
    for (int i = 0; i < 8 && lb1 == 2'b00; i++) begin
      yel++;
      step(1'b0, 1'b0);
    end
    chk("dut1 min_green_len", 8'(yel), 8'd4);

    // Asynchronous reset in the third cycle of B yellow.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0);
      if (phase[0] == 3 && el[0] == 2) found = 1'b1;
    end
    chk("dut0 reach_s3_mid", {7'd0, found}, 8'd1);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    yel = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      if (la0 == 2'b01) yel++;
    end
    chk("dut0 yellow_after_reset", 8'(yel), 8'd5);

    // Randomized sensors with runs of varying length.
    for (int i = 0; i < 400; i++) begin
      logic a, b;
      int   run;
      a   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) != 0);
      run = $urandom_range(1, 12);
      for (int j = 0; j < run; j++) step(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
